// File: rtl/ring_counter.sv
// One-hot ring counter used as a phase/slot sequencer. It provides the one-hot
// state, its binary index and a once-per-revolution wrap pulse.
module ring_counter #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int               IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] counter,
   output logic [IDX_W-1:0] index,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

   // A value is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
   function automatic logic is_onehot(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] low_cleared;
      low_cleared = v & (v - ONE_W);
      return (v != {WIDTH{1'b0}}) && (low_cleared == {WIDTH{1'b0}});
   endfunction

   // Encodes the position of the highest set bit; only meaningful for one-hot input.
   function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   logic [WIDTH-1:0] counter_r;
   logic             wrap_r;
   logic             err_r;

   logic [WIDTH-1:0] next_counter_s;
   logic             next_wrap_s;
   logic             next_err_s;
   logic             state_ok_s;
   logic             load_ok_s;
   logic [WIDTH-1:0] rot_left_s;
   logic [WIDTH-1:0] rot_right_s;

   assign state_ok_s  = is_onehot(counter_r);
   assign load_ok_s   = is_onehot(load_val);
   assign rot_left_s  = {counter_r[WIDTH-2:0], counter_r[WIDTH-1]};
   assign rot_right_s = {counter_r[0], counter_r[WIDTH-1:1]};

   // Next-state selection: init > load > self-correction > step > hold.
   always_comb begin
      next_counter_s = counter_r;
      next_wrap_s    = 1'b0;
      next_err_s     = 1'b0;
      if (init) begin
         next_counter_s = SEED;
      end else if (load) begin
         if (load_ok_s) begin
            next_counter_s = load_val;
         end else begin
            next_counter_s = SEED;
            next_err_s     = 1'b1;
         end
      end else if (!state_ok_s) begin
         // A corrupted ring never steps; it is restored even while en is low.
         next_counter_s = SEED;
         next_err_s     = 1'b1;
      end else if (en) begin
         case (dir)
            1'b0: begin
               next_counter_s = rot_left_s;
               next_wrap_s    = counter_r[WIDTH-1];
            end
            1'b1: begin
               next_counter_s = rot_right_s;
               next_wrap_s    = counter_r[0];
            end
            default: begin
               next_counter_s = SEED;
               next_err_s     = 1'b1;
            end
         endcase
      end else begin
         next_counter_s = counter_r;
      end
   end

   // State and status registers; reset restores the seed asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_r <= SEED;
         wrap_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         counter_r <= next_counter_s;
         wrap_r    <= next_wrap_s;
         err_r     <= next_err_s;
      end
   end

   assign counter = counter_r;
   assign index   = encode(counter_r);
   assign wrap    = wrap_r;
   assign err     = err_r;

endmodule

// File: tb/tb_ring_counter.sv
// Self-checking bench for ring_counter: directed scenarios plus a randomized run
// compared against a position-based reference model.
module tb_ring_counter;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         init;
   logic         en;
   logic         dir;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] counter;
   logic [2:0]   index;
   logic         wrap;
   logic         err;

   int tests;
   int failed;

   // Reference model: the ring is simply a position 0..W-1 of the single hot bit.
   int pos;
   logic exp_wrap;
   logic exp_err;

   ring_counter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .init(init), .en(en), .dir(dir),
      .load(load), .load_val(load_val), .counter(counter), .index(index),
      .wrap(wrap), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] exp_cnt();
      logic [W-1:0] one;
      one = 8'd1;
      return one << pos;
   endfunction

   task automatic model_reset();
      pos = 0;
      exp_wrap = 1'b0;
      exp_err = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model and sample 1 ns after the edge.
   task automatic step(input logic i_init, input logic i_load, input logic i_en,
                       input logic i_dir, input logic [W-1:0] i_lv);
      init = i_init; load = i_load; en = i_en; dir = i_dir; load_val = i_lv;
      @(posedge clk);
      if (i_init) begin
         pos = 0; exp_wrap = 1'b0; exp_err = 1'b0;
      end else if (i_load) begin
         exp_wrap = 1'b0;
         if ($countones(i_lv) == 1) begin
            pos = $clog2(i_lv); exp_err = 1'b0;
         end else begin
            pos = 0; exp_err = 1'b1;
         end
      end else if (i_en) begin
         exp_err = 1'b0;
         if (!i_dir) begin
            exp_wrap = (pos == W - 1);
            pos = (pos + 1) % W;
         end else begin
            exp_wrap = (pos == 0);
            pos = (pos + W - 1) % W;
         end
      end else begin
         exp_wrap = 1'b0; exp_err = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      init = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; load_val = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      // Assert reset between edges: outputs must change without a clock edge.
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      tests++;
      if (counter !== 8'b0000_0001 || wrap !== 1'b0 || err !== 1'b0) begin
         failed++;
         $display("FAIL async_reset: got cnt=%b wrap=%b err=%b exp cnt=00000001 wrap=0 err=0",
                  counter, wrap, err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
         tests++;
         if (counter !== exp_cnt()) begin
            failed++;
            $display("FAIL reset_release_step%0d: got %b exp %b", k, counter, exp_cnt());
         end
      end
   endtask

   task automatic test_free_run_left();
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
         tests++;
         if (counter !== 8'b0000_0001) begin
            failed++;
            $display("FAIL init_hold%0d: got %b exp 00000001", k, counter);
         end
      end
      for (int k = 1; k <= W; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
         tests++;
         if (counter !== exp_cnt() || index !== 3'(k % W) || wrap !== (k == W)) begin
            failed++;
            $display("FAIL left_run%0d: got cnt=%b idx=%0d wrap=%b exp cnt=%b idx=%0d wrap=%b",
                     k, counter, index, wrap, exp_cnt(), k % W, (k == W));
         end
      end
   endtask

   task automatic test_direction();
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0100);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
         tests++;
         if (counter !== exp_cnt() || wrap !== exp_wrap) begin
            failed++;
            $display("FAIL right_step%0d: got cnt=%b wrap=%b exp cnt=%b wrap=%b",
                     k, counter, wrap, exp_cnt(), exp_wrap);
         end
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      tests++;
      if (counter !== 8'b0000_0001 || wrap !== 1'b1) begin
         failed++;
         $display("FAIL dir_toggle: got cnt=%b wrap=%b exp cnt=00000001 wrap=1", counter, wrap);
      end
   endtask

   task automatic test_load();
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'b0010_0000);
      tests++;
      if (counter !== 8'b0010_0000 || index !== 3'd5 || err !== 1'b0) begin
         failed++;
         $display("FAIL load_ok: got cnt=%b idx=%0d err=%b exp cnt=00100000 idx=5 err=0",
                  counter, index, err);
      end
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'b0011_0000);
      tests++;
      if (counter !== 8'b0000_0001 || err !== 1'b1) begin
         failed++;
         $display("FAIL load_bad: got cnt=%b err=%b exp cnt=00000001 err=1", counter, err);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      tests++;
      if (err !== 1'b0 || counter !== 8'b0000_0001) begin
         failed++;
         $display("FAIL load_err_clear: got cnt=%b err=%b exp cnt=00000001 err=0", counter, err);
      end
   endtask

   task automatic test_priority();
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'b0100_0000);
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_1000);
      tests++;
      if (counter !== 8'b0000_0001 || wrap !== 1'b0) begin
         failed++;
         $display("FAIL prio_init: got cnt=%b wrap=%b exp cnt=00000001 wrap=0", counter, wrap);
      end
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'b1000_0000);
      tests++;
      if (counter !== 8'b1000_0000 || wrap !== 1'b0) begin
         failed++;
         $display("FAIL prio_load_over_en: got cnt=%b wrap=%b exp cnt=10000000 wrap=0",
                  counter, wrap);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
         tests++;
         if (counter !== 8'b1000_0000 || wrap !== 1'b0) begin
            failed++;
            $display("FAIL hold%0d: got cnt=%b wrap=%b exp cnt=10000000 wrap=0", k, counter, wrap);
         end
      end
   endtask

   task automatic test_corruption();
      logic [W-1:0] bad [2];
      bad[0] = 8'b0000_0000;
      bad[1] = 8'b0001_0001;
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_1000);
         force dut.counter_r = bad[k];
         #1 release dut.counter_r;
         step(1'b0, 1'b0, k[0], 1'b0, 8'd0);
         pos = 0; exp_wrap = 1'b0; exp_err = 1'b0;
         tests++;
         if (counter !== 8'b0000_0001 || err !== 1'b1 || wrap !== 1'b0) begin
            failed++;
            $display("FAIL corrupt_fix%0d: got cnt=%b err=%b wrap=%b exp cnt=00000001 err=1 wrap=0",
                     k, counter, err, wrap);
         end
         step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
         tests++;
         if (err !== 1'b0 || counter !== 8'b0000_0001) begin
            failed++;
            $display("FAIL corrupt_clear%0d: got cnt=%b err=%b exp cnt=00000001 err=0",
                     k, counter, err);
         end
      end
   endtask

   task automatic test_random();
      logic         r_init, r_load, r_en, r_dir;
      logic [W-1:0] r_lv;
      logic [W-1:0] one;
      one = 8'd1;
      for (int k = 0; k < 300; k++) begin
         r_init = ($urandom_range(0, 15) == 0);
         r_load = ($urandom_range(0, 7) == 0);
         r_en   = ($urandom_range(0, 9) < 7);
         r_dir  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) r_lv = 8'($urandom);
         else                           r_lv = one << $urandom_range(0, W - 1);
         step(r_init, r_load, r_en, r_dir, r_lv);
         tests++;
         if (counter !== exp_cnt() || index !== 3'(pos) || wrap !== exp_wrap || err !== exp_err) begin
            failed++;
            $display("FAIL random%0d: got cnt=%b idx=%0d wrap=%b err=%b exp cnt=%b idx=%0d wrap=%b err=%b",
                     k, counter, index, wrap, err, exp_cnt(), pos, exp_wrap, exp_err);
         end
      end
   endtask

   initial begin
      tests = 0;
      failed = 0;
      test_reset();
      test_free_run_left();
      test_direction();
      test_load();
      test_priority();
      test_corruption();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
